// File: rtl/mlp_seq_engine.sv
// mlp_seq_engine: time-multiplexed 2-layer MLP (ReLU hidden, linear output) on a single signed MAC
module mlp_seq_engine #(
  parameter int BITS_PER_WORD = 8,
  parameter int IN_SIZE = 2,
  parameter int HID_SIZE = 2,
  parameter int OUT_SIZE = 1,
  parameter int ACC_W = 20,
  parameter int N_ADDR_W = 2,
  parameter int M_ADDR_W = 2
)(
  input  logic clk,
  input  logic reset_n,
  input  logic weights_en,
  output logic weights_ready,
  input  logic weights_layer_address,
  input  logic [N_ADDR_W-1:0] weights_n_address,
  input  logic [M_ADDR_W-1:0] weights_m_address,
  input  logic [BITS_PER_WORD-1:0] weights_data,
  input  logic in_valid,
  output logic in_ready,
  input  logic [IN_SIZE*BITS_PER_WORD-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [OUT_SIZE*BITS_PER_WORD-1:0] out_data,
  output logic busy
);
  localparam int B = BITS_PER_WORD;
  localparam int NR = 1 << N_ADDR_W;
  localparam int NM = 1 << M_ADDR_W;
  localparam logic [N_ADDR_W-1:0] R1 = N_ADDR_W'(IN_SIZE);
  localparam logic [N_ADDR_W-1:0] R2 = N_ADDR_W'(HID_SIZE);
  localparam logic [M_ADDR_W-1:0] J1 = M_ADDR_W'(HID_SIZE - 1);
  localparam logic [M_ADDR_W-1:0] J2 = M_ADDR_W'(OUT_SIZE - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((1 << (B - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX - 1;
  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;
  state_t state, state_n;
  logic signed [B-1:0] w1 [NR][NM];
  logic signed [B-1:0] w2 [NR][NM];
  logic signed [B-1:0] x [NR];
  logic signed [B-1:0] h [NR];
  logic signed [B-1:0] y [NM];
  logic signed [ACC_W-1:0] acc, acc_n;
  logic [N_ADDR_W-1:0] r, rm1, fan;
  logic [M_ADDR_W-1:0] j, last_j;
  logic signed [B-1:0] a, w, s;
  logic signed [2*B-1:0] prod;
  logic [OUT_SIZE*B-1:0] y_flat;
  logic l1, mac, row_end;
  assign in_ready = state == IDLE;
  assign weights_ready = state == IDLE;
  assign busy = state != IDLE;
  // row 0 of each column is the bias, so it enters the sum unmultiplied
  always_comb begin
    l1 = state == L1;
    mac = l1 || state == L2;
    fan = l1 ? R1 : R2;
    last_j = l1 ? J1 : J2;
    rm1 = r - N_ADDR_W'(1);
    w = l1 ? w1[r][j] : w2[r][j];
    a = l1 ? x[rm1] : h[rm1];
    prod = (2*B)'(a) * (2*B)'(w);
    acc_n = acc + (r == '0 ? ACC_W'(w) : ACC_W'(prod));
    s = acc_n > ACC_MAX ? ACC_MAX[B-1:0] : acc_n < ACC_MIN ? ACC_MIN[B-1:0] : acc_n[B-1:0];
    row_end = r == fan;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && in_valid) state_n = L1;
    if (mac && row_end && j == last_j) state_n = l1 ? L2 : DONE;
    if (state == DONE && out_valid && out_ready) state_n = IDLE;
  end
  always_comb begin
    y_flat = '0;
    for (int i = 0; i < OUT_SIZE; i++) y_flat[i*B +: B] = y[M_ADDR_W'(i)];
  end
  always_ff @(posedge clk) state <= !reset_n ? IDLE : state_n;
  // weight RAMs have no reset so a reset never erases a loaded network
  always_ff @(posedge clk)
    if (weights_en && weights_ready) begin
      if (!weights_layer_address && weights_n_address <= R1 && weights_m_address <= J1)
        w1[weights_n_address][weights_m_address] <= weights_data;
      if (weights_layer_address && weights_n_address <= R2 && weights_m_address <= J2)
        w2[weights_n_address][weights_m_address] <= weights_data;
    end
  // out_valid rises one cycle after entering DONE, giving the fixed N+1 latency
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
      r <= '0;
      j <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      if (state == IDLE && in_valid)
        for (int k = 0; k < IN_SIZE; k++) x[N_ADDR_W'(k)] <= in_data[k*B +: B];
      if (mac) begin
        acc <= row_end ? '0 : acc_n;
        r <= row_end ? '0 : r + N_ADDR_W'(1);
        if (row_end) begin
          j <= j == last_j ? '0 : j + M_ADDR_W'(1);
          if (l1) h[N_ADDR_W'(j)] <= s[B-1] ? '0 : s;
          else y[j] <= s;
        end
      end
      if (state == DONE && !out_valid) begin
        out_valid <= 1'b1;
        out_data <= y_flat;
      end else if (out_valid && out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mlp_seq_engine.sv
// tb_mlp_seq_engine: table-driven and randomized checks of mlp_seq_engine at default and swept parameters
module tb_mlp_seq_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int total = 0, bad = 0;
  logic a_wen, a_wrdy, a_wl, a_iv, a_ir, a_ov, a_or, a_busy;
  logic [1:0] a_wn, a_wm;
  logic [7:0] a_wd, a_od;
  logic [15:0] a_id;
  mlp_seq_engine dut_a (
    .clk(clk), .reset_n(rst_n), .weights_en(a_wen), .weights_ready(a_wrdy),
    .weights_layer_address(a_wl), .weights_n_address(a_wn), .weights_m_address(a_wm),
    .weights_data(a_wd), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .busy(a_busy));
  logic b_wen, b_wrdy, b_wl, b_iv, b_ir, b_ov, b_or, b_busy;
  logic [2:0] b_wn;
  logic [1:0] b_wm;
  logic [11:0] b_wd;
  logic [35:0] b_id;
  logic [23:0] b_od;
  mlp_seq_engine #(.BITS_PER_WORD(12), .IN_SIZE(3), .HID_SIZE(4), .OUT_SIZE(2),
                   .ACC_W(28), .N_ADDR_W(3), .M_ADDR_W(2)) dut_b (
    .clk(clk), .reset_n(rst_n), .weights_en(b_wen), .weights_ready(b_wrdy),
    .weights_layer_address(b_wl), .weights_n_address(b_wn), .weights_m_address(b_wm),
    .weights_data(b_wd), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .busy(b_busy));

  typedef struct {int x0; int x1; int y;} vec_t;
  vec_t xv[4];
  int mw1[5][4], mw2[5][4], mx[4], my[4];

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int b);
    int hi = (1 << (b - 1)) - 1;
    return v > hi ? hi : v < -hi - 1 ? -hi - 1 : v;
  endfunction

  // network evaluated straight from the weight tables with integer arithmetic
  function automatic void model(input int ni, input int nh, input int no, input int b);
    int hv[4];
    int acc;
    for (int j = 0; j < nh; j++) begin
      acc = mw1[0][j];
      for (int k = 0; k < ni; k++) acc += mx[k] * mw1[k+1][j];
      hv[j] = sat(acc, b) < 0 ? 0 : sat(acc, b);
    end
    for (int i = 0; i < no; i++) begin
      acc = mw2[0][i];
      for (int k = 0; k < nh; k++) acc += hv[k] * mw2[k+1][i];
      my[i] = sat(acc, b);
    end
  endfunction

  function automatic int rnd(input int r);
    return int'($urandom_range(0, 2 * r - 1)) - r;
  endfunction

  task automatic wr_a(input int l, input int n, input int m, input int d);
    @(negedge clk);
    a_wen = 1'b1; a_wl = 1'(l); a_wn = 2'(n); a_wm = 2'(m); a_wd = 8'(d);
    @(negedge clk);
    a_wen = 1'b0;
  endtask

  task automatic wait_a(output int lat);
    lat = 0;
    while (!a_ov && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack_a;
    a_or = 1'b1;
    @(negedge clk);
    a_or = 1'b0;
  endtask

  task automatic run_a(input int x0, input int x1, output int y, output int lat);
    @(negedge clk);
    a_id = {8'(x1), 8'(x0)};
    a_iv = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    wait_a(lat);
    y = int'($signed(a_od));
    ack_a();
  endtask

  task automatic load_xor;
    wr_a(0, 0, 0, 0); wr_a(0, 0, 1, -1);
    wr_a(0, 1, 0, 1); wr_a(0, 1, 1, 1);
    wr_a(0, 2, 0, 1); wr_a(0, 2, 1, 1);
    wr_a(1, 0, 0, 0); wr_a(1, 1, 0, 1); wr_a(1, 2, 0, -2);
  endtask

  task automatic wr_b(input int l, input int n, input int m, input int d);
    @(negedge clk);
    b_wen = 1'b1; b_wl = 1'(l); b_wn = 3'(n); b_wm = 2'(m); b_wd = 12'(d);
    @(negedge clk);
    b_wen = 1'b0;
  endtask

  task automatic run_b(output int lat);
    @(negedge clk);
    for (int k = 0; k < 3; k++) b_id[k*12 +: 12] = 12'(mx[k]);
    b_iv = 1'b1;
    @(negedge clk);
    b_iv = 1'b0;
    lat = 0;
    while (!b_ov && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    b_or = 1'b1;
    @(negedge clk);
    b_or = 1'b0;
  endtask

  initial begin
    int y, lat, wr, xr;
    xv[0] = '{0, 0, 0}; xv[1] = '{0, 1, 1}; xv[2] = '{1, 0, 1}; xv[3] = '{1, 1, 0};
    rst_n = 1'b0;
    {a_wen, a_wl, a_wn, a_wm, a_wd, a_iv, a_id, a_or} = '0;
    {b_wen, b_wl, b_wn, b_wm, b_wd, b_iv, b_id, b_or} = '0;
    repeat (3) @(negedge clk);
    chk("rst out_valid", a_ov, 0);
    chk("rst out_data", a_od, 0);
    chk("rst busy", a_busy, 0);
    chk("rst in_ready", a_ir, 1);
    chk("rst weights_ready", a_wrdy, 1);
    rst_n = 1'b1;

    load_xor();
    foreach (xv[i]) begin
      run_a(xv[i].x0, xv[i].x1, y, lat);
      chk($sformatf("xor(%0d,%0d) out", xv[i].x0, xv[i].x1), y, xv[i].y);
      chk($sformatf("xor(%0d,%0d) latency", xv[i].x0, xv[i].x1), lat, 10);
    end

    for (int n = 0; n < 3; n++) for (int m = 0; m < 2; m++) wr_a(0, n, m, 127);
    wr_a(1, 0, 0, 0); wr_a(1, 1, 0, 1); wr_a(1, 2, 0, 1);
    run_a(127, 127, y, lat);
    chk("sat positive", y, 127);
    wr_a(1, 1, 0, -128); wr_a(1, 2, 0, -128);
    run_a(127, 127, y, lat);
    chk("sat negative", y, -128);

    load_xor();
    @(negedge clk);
    a_id = 16'h0100; a_iv = 1'b1;
    @(negedge clk);
    a_id = 16'h0101;
    wait_a(lat);
    chk("bp latency", lat, 10);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d out_valid", c), a_ov, 1);
      chk($sformatf("bp hold%0d out_data", c), a_od, 1);
      chk($sformatf("bp hold%0d in_ready", c), a_ir, 0);
    end
    ack_a();
    chk("bp after ack out_valid", a_ov, 0);
    chk("bp after ack in_ready", a_ir, 1);
    chk("bp after ack out_data", a_od, 1);
    @(negedge clk);
    a_iv = 1'b0;
    chk("bp second busy", a_busy, 1);
    wait_a(lat);
    chk("bp second latency", lat, 10);
    chk("bp second out", int'($signed(a_od)), 0);
    ack_a();

    @(negedge clk);
    a_id = 16'h0001; a_iv = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst out_valid", a_ov, 0);
    chk("midrst in_ready", a_ir, 1);
    chk("midrst busy", a_busy, 0);
    rst_n = 1'b1;
    run_a(1, 0, y, lat);
    chk("post reset xor out", y, 1);
    chk("post reset latency", lat, 10);

    @(negedge clk);
    a_id = 16'h0001; a_iv = 1'b1;
    @(negedge clk);
    a_iv = 1'b0;
    repeat (7) @(negedge clk);
    chk("L2 weights_ready", a_wrdy, 0);
    a_wen = 1'b1; a_wl = 1'b0; a_wn = 2'd1; a_wm = 2'd0; a_wd = 8'hFB;
    @(negedge clk);
    a_wen = 1'b0;
    wait_a(lat);
    chk("busy write inflight out", int'($signed(a_od)), 1);
    ack_a();
    run_a(1, 0, y, lat);
    chk("busy write dropped", y, 1);

    @(negedge clk);
    a_wen = 1'b1; a_wl = 1'b0; a_wn = 2'd1; a_wm = 2'd0; a_wd = 8'hFB;
    a_id = 16'h0001; a_iv = 1'b1;
    @(negedge clk);
    a_wen = 1'b0; a_iv = 1'b0;
    wait_a(lat);
    chk("same-edge write used", int'($signed(a_od)), 0);
    ack_a();
    wr_a(0, 1, 0, 1);
    run_a(1, 0, y, lat);
    chk("restored xor out", y, 1);

    for (int set = 0; set < 2; set++) begin
      wr = set == 0 ? 128 : 8;
      xr = set == 0 ? 128 : 16;
      for (int n = 0; n < 3; n++) for (int m = 0; m < 2; m++) begin
        mw1[n][m] = rnd(wr);
        wr_a(0, n, m, mw1[n][m]);
      end
      for (int n = 0; n < 3; n++) begin
        mw2[n][0] = rnd(wr);
        wr_a(1, n, 0, mw2[n][0]);
      end
      for (int t = 0; t < 4; t++) begin
        mx[0] = rnd(xr); mx[1] = rnd(xr);
        model(2, 2, 1, 8);
        run_a(mx[0], mx[1], y, lat);
        chk($sformatf("rand a s%0d t%0d out", set, t), y, my[0]);
        chk($sformatf("rand a s%0d t%0d latency", set, t), lat, 10);
      end
    end

    for (int set = 0; set < 2; set++) begin
      wr = set == 0 ? 2048 : 40;
      xr = set == 0 ? 2048 : 100;
      for (int n = 0; n < 4; n++) for (int m = 0; m < 4; m++) begin
        mw1[n][m] = rnd(wr);
        wr_b(0, n, m, mw1[n][m]);
      end
      for (int n = 0; n < 5; n++) for (int m = 0; m < 2; m++) begin
        mw2[n][m] = rnd(wr);
        wr_b(1, n, m, mw2[n][m]);
      end
      for (int t = 0; t < 4; t++) begin
        for (int k = 0; k < 3; k++) mx[k] = rnd(xr);
        model(3, 4, 2, 12);
        run_b(lat);
        chk($sformatf("sweep s%0d t%0d latency", set, t), lat, 27);
        for (int i = 0; i < 2; i++)
          chk($sformatf("sweep s%0d t%0d y%0d", set, t, i), int'($signed(b_od[i*12 +: 12])), my[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
